// File: rtl/move_ctrl_m_pkg.sv
// Shared board geometry, cell encodings and controller state type for the move controller slice.
package move_ctrl_m_pkg;

  localparam int BOARD_ROWS  = 3;
  localparam int BOARD_COLS  = 3;
  localparam int BOARD_CELLS = BOARD_ROWS * BOARD_COLS;
  localparam int INDEX_W     = 4;

  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [1:0]         cell_t;
  typedef logic [3:0]         count_t;

  localparam cell_t CELL_BLANK = 2'd0;
  localparam cell_t CELL_X     = 2'd1;
  localparam cell_t CELL_O     = 2'd2;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT
  } mc_state_e;

  function automatic cell_t other_side(input cell_t side);
    return (side == CELL_X) ? CELL_O : CELL_X;
  endfunction

endpackage

// File: rtl/toggle_sync_m.sv
// Synchronises the board's refresh toggle and emits a one-cycle pulse per level change.
module toggle_sync_m #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic toggle
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Reset preloads every stage from the live level so a stale toggle never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{din}};
      hist_q <= din;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign toggle = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/move_ctrl_m.sv
// Move initiator for board_m: accepts moves, stamps the side to move, strobes submit
// and waits for the refresh toggle; also issues board clears.
module move_ctrl_m
  import move_ctrl_m_pkg::*;
#(
  parameter int    SUBMIT_HI    = 2,
  parameter int    ACK_TIMEOUT  = 8,
  parameter int    SYNC_STAGES  = 2,
  parameter cell_t FIRST_PLAYER = CELL_X
) (
  input  logic   clk,
  input  logic   reset,
  input  index_t move_loc,
  input  logic   move_valid,
  output logic   move_ready,
  input  logic   new_game,
  input  logic   game_over,
  input  logic   refresh,
  output index_t update_loc,
  output cell_t  update_val,
  output logic   submit,
  output logic   board_reset,
  output cell_t  player,
  output count_t move_count,
  output logic   board_full,
  output logic   move_accepted,
  output logic   move_rejected,
  output logic   ack_late
);

  localparam int CNT_MAX = (SUBMIT_HI + 1 > ACK_TIMEOUT) ? SUBMIT_HI + 1 : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mc_state_e        state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             pending_q, pending_n;
  logic             toggle;

  index_t loc_n;
  cell_t  val_n, player_n;
  count_t count_n;
  logic   sub_n, brst_n, acc_n, rej_n, late_n;

  toggle_sync_m #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (refresh),
    .toggle (toggle)
  );

  assign move_ready = (state_q == ST_IDLE) && !pending_q && !new_game;

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    pending_n = pending_q;
    loc_n     = update_loc;
    val_n     = update_val;
    sub_n     = submit;
    brst_n    = board_reset;
    player_n  = player;
    count_n   = move_count;
    acc_n     = 1'b0;
    rej_n     = 1'b0;
    late_n    = toggle && (state_q != ST_WAIT);

    if (new_game && (state_q == ST_SETUP || state_q == ST_STROBE || state_q == ST_WAIT))
      pending_n = 1'b1;

    case (state_q)
      // cnt 0 drives the clear address, cnt 1 is the setup cycle, then SUBMIT_HI strobe cycles.
      ST_CLEAR: begin
        pending_n = 1'b0;
        cnt_n     = cnt_q + CNT_W'(1);
        if (cnt_q == '0) begin
          loc_n  = index_t'(BOARD_CELLS);
          brst_n = 1'b1;
          sub_n  = 1'b0;
        end else if (cnt_q == CNT_W'(SUBMIT_HI + 1)) begin
          sub_n    = 1'b0;
          brst_n   = 1'b0;
          player_n = FIRST_PLAYER;
          count_n  = '0;
          cnt_n    = '0;
          state_n  = ST_IDLE;
        end else begin
          sub_n = 1'b1;
        end
      end
      ST_IDLE: begin
        cnt_n = '0;
        if (new_game) begin
          state_n = ST_CLEAR;
        end else if (move_valid) begin
          if (move_loc >= index_t'(BOARD_CELLS) || board_full || game_over) begin
            rej_n = 1'b1;
          end else begin
            loc_n   = move_loc;
            val_n   = player;
            state_n = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        sub_n   = 1'b1;
        cnt_n   = CNT_W'(1);
        state_n = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == CNT_W'(SUBMIT_HI)) begin
          sub_n   = 1'b0;
          cnt_n   = '0;
          state_n = ST_WAIT;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        cnt_n = cnt_q + CNT_W'(1);
        if (toggle || cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          if (toggle) begin
            acc_n    = 1'b1;
            player_n = other_side(player);
            if (move_count != count_t'(BOARD_CELLS))
              count_n = move_count + count_t'(1);
          end else begin
            rej_n = 1'b1;
          end
          cnt_n   = '0;
          state_n = (pending_q || new_game) ? ST_CLEAR : ST_IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      update_loc    <= '0;
      update_val    <= CELL_BLANK;
      submit        <= 1'b0;
      board_reset   <= 1'b0;
      player        <= FIRST_PLAYER;
      move_count    <= '0;
      board_full    <= 1'b0;
      move_accepted <= 1'b0;
      move_rejected <= 1'b0;
      ack_late      <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      pending_q     <= pending_n;
      update_loc    <= loc_n;
      update_val    <= val_n;
      submit        <= sub_n;
      board_reset   <= brst_n;
      player        <= player_n;
      move_count    <= count_n;
      board_full    <= (count_n == count_t'(BOARD_CELLS));
      move_accepted <= acc_n;
      move_rejected <= rej_n;
      ack_late      <= late_n;
    end
  end

endmodule

// File: tb/tb_move_ctrl_m.sv
// Scoreboard bench for move_ctrl_m: a rule-level reference predicts each move outcome,
// a board_m stand-in answers submits, and a monitor checks every DUT result pulse and clear.
module tb_move_ctrl_m;
  import move_ctrl_m_pkg::*;

  localparam int SH  = 2;
  localparam int ACK = 8;

  logic   clk = 1'b0, reset = 1'b0;
  index_t move_loc = '0;
  logic   move_valid = 1'b0, new_game = 1'b0, game_over = 1'b0, refresh = 1'b0;
  logic   move_ready, submit, board_reset, board_full, move_accepted, move_rejected, ack_late;
  index_t update_loc;
  cell_t  update_val, player;
  count_t move_count;

  move_ctrl_m #(.SUBMIT_HI(SH), .ACK_TIMEOUT(ACK), .SYNC_STAGES(2), .FIRST_PLAYER(CELL_X)) dut (
    .clk(clk), .reset(reset), .move_loc(move_loc), .move_valid(move_valid),
    .move_ready(move_ready), .new_game(new_game), .game_over(game_over), .refresh(refresh),
    .update_loc(update_loc), .update_val(update_val), .submit(submit),
    .board_reset(board_reset), .player(player), .move_count(move_count),
    .board_full(board_full), .move_accepted(move_accepted), .move_rejected(move_rejected),
    .ack_late(ack_late)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // board_m stand-in: writes blank cells on submit rising edge, answers with a delayed toggle
  cell_t bm [9];
  logic  sub_q = 1'b0, inj = 1'b0;
  int    tog = 0;
  always @(posedge clk) begin
    sub_q <= submit;
    if (tog == 1 || inj) refresh <= ~refresh;
    if (tog > 0) tog <= tog - 1;
    if (board_reset) begin
      foreach (bm[i]) bm[i] <= CELL_BLANK;
    end else if (submit && !sub_q && int'(update_loc) < 9) begin
      if (bm[int'(update_loc)] == CELL_BLANK) begin
        bm[int'(update_loc)] <= update_val;
        tog <= 1 + int'($urandom_range(0, 3));
      end
    end
  end

  // reference model: rules of play, independent of controller timing
  typedef enum int {K_ACC, K_IMM, K_TMO, K_CLR} kind_e;
  typedef struct {
    kind_e kind;
    int    n;
    int    loc;
    int    val;
    int    plyr;
    int    cnt;
  } exp_t;
  exp_t q[$];
  int   rb [9];
  int   rplayer = 1, rcount = 0, late_exp = 0;

  function automatic void ref_clear();
    foreach (rb[i]) rb[i] = 0;
    rplayer = 1;
    rcount  = 0;
  endfunction

  function automatic exp_t predict(input int loc, input bit go);
    exp_t e;
    e.n = cyc + 1; e.loc = loc; e.val = rplayer;
    if (loc >= 9 || rcount == 9 || go) e.kind = K_IMM;
    else if (rb[loc] != 0) e.kind = K_TMO;
    else begin
      e.kind = K_ACC;
      rb[loc] = rplayer;
      rplayer = 3 - rplayer;
      rcount++;
    end
    e.plyr = rplayer; e.cnt = rcount;
    return e;
  endfunction

  task automatic push_clear();
    exp_t e;
    e.kind = K_CLR; e.n = cyc; e.loc = 9; e.val = 0; e.plyr = 1; e.cnt = 0;
    q.push_back(e);
    ref_clear();
  endtask

  // monitor
  int   mv_sub = 0, clr_sub = 0, clr_badloc = 0, late_seen = 0;
  logic br_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      mv_sub = 0; clr_sub = 0; clr_badloc = 0; br_q = 1'b0;
    end else begin
      if (board_reset) begin
        if (submit) clr_sub++;
        if (update_loc != index_t'(9)) clr_badloc++;
      end else if (submit) mv_sub++;
      if (ack_late) late_seen++;
      if (br_q && !board_reset) begin
        chk("clear_in_order", 32'(q.size() > 0 && q[0].kind == K_CLR), 1);
        if (q.size() > 0 && q[0].kind == K_CLR) begin
          e = q.pop_front();
          chk("clear_submit_cycles", clr_sub, SH);
          chk("clear_loc_invalid", clr_badloc, 0);
          chk("clear_player", player, e.plyr);
          chk("clear_count", move_count, e.cnt);
          chk("clear_full", board_full, 0);
          chk("clear_ready", move_ready, 1);
        end
        clr_sub = 0; clr_badloc = 0; mv_sub = 0;
      end
      br_q = board_reset;
      if (move_accepted || move_rejected) begin
        chk("result_in_order", 32'(q.size() > 0 && q[0].kind != K_CLR), 1);
        if (q.size() > 0 && q[0].kind != K_CLR) begin
          e = q.pop_front();
          chk("accepted", move_accepted, e.kind == K_ACC);
          chk("rejected", move_rejected, e.kind != K_ACC);
          if (e.kind == K_IMM) begin
            chk("imm_latency", cyc, e.n);
            chk("imm_no_submit", mv_sub, 0);
          end else begin
            if (e.kind == K_TMO) chk("timeout_latency", cyc, e.n + 1 + SH + ACK);
            else chk("accept_window", 32'(cyc >= e.n + 2 + SH && cyc <= e.n + 1 + SH + ACK), 1);
            chk("move_submit_cycles", mv_sub, SH);
            chk("move_loc", update_loc, e.loc);
            chk("move_val", update_val, e.val);
          end
          chk("player", player, e.plyr);
          chk("move_count", move_count, e.cnt);
          chk("board_full", board_full, e.cnt == 9);
        end
        mv_sub = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_quiet();
    int t = 0;
    while ((q.size() != 0 || !move_ready) && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) chk("settle_bound", 32'(q.size() == 0 && move_ready), 1);
  endtask

  task automatic do_move(input int loc, input bit go, input bit ngm);
    exp_t e;
    wait_quiet();
    game_over = go;
    e = predict(loc, go);
    q.push_back(e);
    move_loc = index_t'(loc);
    move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    game_over = 1'b0;
    if (ngm && e.kind != K_IMM) begin
      repeat (3) step();
      new_game = 1'b1;
      push_clear();
      step();
      new_game = 1'b0;
    end
    wait_quiet();
  endtask

  task automatic idle_new_game();
    wait_quiet();
    new_game = 1'b1;
    push_clear();
    step();
    new_game = 1'b0;
    wait_quiet();
  endtask

  task automatic inject_toggle();
    wait_quiet();
    inj = 1'b1;
    late_exp++;
    step();
    inj = 1'b0;
    repeat (4) step();
  endtask

  task automatic check_reset_state();
    chk("rst_submit", submit, 0);
    chk("rst_board_reset", board_reset, 0);
    chk("rst_update_loc", update_loc, 0);
    chk("rst_update_val", update_val, CELL_BLANK);
    chk("rst_player", player, CELL_X);
    chk("rst_count", move_count, 0);
    chk("rst_pulses", {move_accepted, move_rejected, ack_late, board_full}, 0);
    chk("rst_ready", move_ready, 0);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) step();
    check_reset_state();
    push_clear();
    reset = 1'b0;
    wait_quiet();

    do_move(4, 1'b0, 1'b0);
    do_move(4, 1'b0, 1'b0);
    do_move(9, 1'b0, 1'b0);
    do_move(0, 1'b1, 1'b0);
    inject_toggle();

    // new_game and move_valid together: clear wins and nothing is transferred
    wait_quiet();
    new_game = 1'b1; move_valid = 1'b1; move_loc = index_t'(0);
    #1 chk("ready_low_on_new_game", move_ready, 0);
    push_clear();
    step();
    new_game = 1'b0; move_valid = 1'b0;
    wait_quiet();

    for (int i = 0; i < 9; i++) do_move(i, 1'b0, 1'b0);
    do_move(4, 1'b0, 1'b0);
    idle_new_game();
    do_move(2, 1'b0, 1'b1);
    do_move(2, 1'b0, 1'b1);

    for (int i = 0; i < 70; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8) idle_new_game();
      else if (r < 16) inject_toggle();
      else do_move(int'($urandom_range(0, 10)), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 9) == 0);
    end

    // asynchronous reset while the submit strobe is high
    idle_new_game();
    move_loc = index_t'(0); move_valid = 1'b1;
    step();
    move_valid = 1'b0;
    step();
    chk("strobe_submit", submit, 1);
    #2 reset = 1'b1;
    #1 chk("async_reset_submit", submit, 0);
    q.delete();
    ref_clear();
    repeat (5) step();
    check_reset_state();
    push_clear();
    reset = 1'b0;
    do_move(0, 1'b0, 1'b0);
    do_move(8, 1'b0, 1'b0);

    wait_quiet();
    repeat (5) step();
    chk("ack_late_count", late_seen, late_exp);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
